// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant IDs and
// the ACCESS wait-counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_F = 1'b1
    } gnt_id_e;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signals of the data-memory port arbiter.
// slave = arbiter side, master = pipeline/memory environment side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              ack_i;
    logic              stall_i;

    logic              req_f;
    logic              we_f;
    logic [ADDR_W-1:0] addr_f;
    logic [DATA_W-1:0] wdata_f;
    logic              ack_f;
    logic              stall_f;

    logic [DATA_W-1:0] rdata;
    logic              resp_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        input  req_f, we_f, addr_f, wdata_f,
        input  mem_rdata, mem_ready,
        output ack_i, stall_i, ack_f, stall_f,
        output rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        output req_f, we_f, addr_f, wdata_f,
        output mem_rdata, mem_ready,
        input  ack_i, stall_i, ack_f, stall_f,
        input  rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between the integer and FP requesters; the
// requester being acked this cycle is masked out so its held req is ignored.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_f,
    input  gnt_id_e    last_grant,
    input  logic [1:0] mask,
    output logic       gnt_vld,
    output gnt_id_e    gnt_id
);

    logic elig_i;
    logic elig_f;

    assign elig_i = req_i & ~mask[0];
    assign elig_f = req_f & ~mask[1];

    always_comb begin
        gnt_vld = elig_i | elig_f;
        gnt_id  = GNT_I;
        if (elig_i && elig_f) begin
            gnt_id = (last_grant == GNT_I) ? GNT_F : GNT_I;
        end else if (elig_f) begin
            gnt_id = GNT_F;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between integer and FP MEM stages.
// Optional DMEM_ARB_PERF_EN adds saturating conflict/timeout counters.
//
// state  | meaning
// IDLE   | port free, waiting for a request
// ACCESS | mem_en high, waiting for mem_ready or timeout
// RESP   | one-cycle ack to the granted requester; may grant the other
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         timeout_cnt
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    arb_state_e              state_q, state_d;
    gnt_id_e                 gnt_q, gnt_d;
    gnt_id_e                 last_q, last_d;
    logic                    we_q, we_d;
    logic [ADDR_W-3:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;

    logic                    arb_vld;
    gnt_id_e                 arb_id;
    logic [1:0]              mask;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;

    assign mask = (state_q != RESP) ? 2'b00 :
                  (gnt_q == GNT_I)  ? 2'b01 : 2'b10;

    rr_arb2 u_rr_arb2 (
        .req_i      (bus.req_i),
        .req_f      (bus.req_f),
        .last_grant (last_q),
        .mask       (mask),
        .gnt_vld    (arb_vld),
        .gnt_id     (arb_id)
    );

    assign sel_we    = (arb_id == GNT_F) ? bus.we_f    : bus.we_i;
    assign sel_addr  = (arb_id == GNT_F) ? bus.addr_f  : bus.addr_i;
    assign sel_wdata = (arb_id == GNT_F) ? bus.wdata_f : bus.wdata_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_I;
            last_q  <= GNT_F;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ACCESS: begin
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and RESP share the grant path so RESP can hand the
                // port straight to the other requester.
                state_d = IDLE;
                if (arb_vld) begin
                    gnt_d   = arb_id;
                    last_d  = arb_id;
                    we_d    = sel_we;
                    waddr_d = sel_addr[ADDR_W-1:2];
                    wdata_d = sel_wdata;
                    cnt_d   = '0;
                    if (sel_addr[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
        endcase
    end

    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) & we_q;
    assign bus.mem_addr  = {waddr_q, 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.ack_i     = (state_q == RESP) & (gnt_q == GNT_I);
    assign bus.ack_f     = (state_q == RESP) & (gnt_q == GNT_F);
    assign bus.stall_i   = bus.req_i & ~bus.ack_i;
    assign bus.stall_f   = bus.req_f & ~bus.ack_f;
    assign bus.rdata     = rdata_q;
    assign bus.resp_err  = err_q;

`ifdef DMEM_ARB_PERF_EN
    logic timeout_hit;
    logic conflict_hit;

    assign timeout_hit  = (state_q == ACCESS) & ~bus.mem_ready & (cnt_q == TMO_LAST);
    assign conflict_hit = bus.req_i & bus.req_f & (bus.stall_i | bus.stall_f);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (conflict_hit && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            if (timeout_hit && !(&timeout_cnt)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single data-memory port between the integer MEM stage and the FP MEM stage (FSW/FLW traffic).
- Each requester holds a registered request until it receives a one-cycle ack.
- The arbiter sequences a multi-cycle memory handshake and returns read data plus an error flag.
- It drives per-requester stall outputs that feed the pipeline hazard logic (the integer pipeline's mem_stall path).

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data word width
TIMEOUT, 15, max ACCESS cycles waiting for mem_ready before error (must be >=1, <=255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_i  in  1  integer requester: request valid
we_i  in  1  integer requester: 1=store, 0=load
addr_i  in  ADDR_W  integer requester: byte address
wdata_i  in  DATA_W  integer requester: store data
ack_i  out  1  integer requester: one-cycle completion pulse
stall_i  out  1  integer requester: req_i & ~ack_i
req_f  in  1  FP requester: request valid
we_f  in  1  FP requester: 1=FSW, 0=FLW
addr_f  in  ADDR_W  FP requester: byte address
wdata_f  in  DATA_W  FP requester: store data
ack_f  out  1  FP requester: one-cycle completion pulse
stall_f  out  1  FP requester: req_f & ~ack_f
rdata  out  DATA_W  load data, valid while ack_i or ack_f is high
resp_err  out  1  error flag, valid with the ack (misaligned or timeout)
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address (word aligned)
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_en, mem_we, ack_i, ack_f, resp_err = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - last_grant=FP, so the integer requester wins the first conflict.
- Requester rules:
  - req/we/addr/wdata stay stable from assertion until the ack cycle.
  - The requester deasserts req or presents a new request in the cycle after ack.
  - The arbiter ignores the just-served requester's req during that requester's ack cycle.
- IDLE state:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: round-robin; grant the requester not equal to last_grant.
  - On grant: register we/addr/wdata and the grant ID, update last_grant, go to ACCESS.
  - Misaligned grant (addr[1:0]!=0): go directly to RESP with err=1 and no memory access.
- ACCESS state:
  - mem_en=1, mem_we/mem_addr/mem_wdata driven from the latched registers.
  - A wait counter starts at 0 and increments each cycle.
  - mem_ready=1: capture mem_rdata (loads only; stores capture 0), err=0, go to RESP.
  - Counter reaches TIMEOUT with no mem_ready: err=1, rdata=0, drop mem_en, go to RESP.
- RESP state:
  - ack of the granted requester =1 for exactly one cycle; rdata/resp_err valid.
  - Other requester pending: grant it directly (RESP->ACCESS, or RESP->RESP if misaligned), giving back-to-back service.
  - Otherwise go to IDLE.
- Latency: request seen at edge 0, ACCESS in cycle 1, zero-wait memory asserts mem_ready in cycle 1, ack in cycle 2. Each extra wait cycle adds 1.
- Fairness: under continuous dual requests, grants alternate I,F,I,F.
- Never assert ack_i and ack_f together. Never assert mem_en outside ACCESS.
- mem_ready outside ACCESS is ignored.
- Reset mid-ACCESS aborts the access: no ack, mem_en drops asynchronously.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs conflict_cnt[15:0] and timeout_cnt[15:0].
  - conflict_cnt increments each cycle both reqs are pending and one is stalled.
  - timeout_cnt increments per timeout.
  - Both are saturating, reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Grant IDs (GNT_I=1'b0, GNT_F=1'b1).
  - Wait-counter width localparam.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req_i, req_f, last_grant, mask of the just-served requester) -> grant valid + ID.

Test Plan:
- Integer load alone, addr=0x10, mem_ready in the first ACCESS cycle, mem_rdata=0xDEADBEEF -> ack_i in cycle 2, rdata=0xDEADBEEF, resp_err=0, ack_f never asserted.
- req_i and req_f raised the same cycle after reset, each held until its ack, zero-wait memory -> integer served first, FP ack follows exactly 2 cycles later via RESP->ACCESS, stall_f=1 until its ack.
- Continuous dual requests for 8 transactions -> grant order I,F,I,F,I,F,I,F; conflict_cnt (if DMEM_ARB_PERF_EN) increments every cycle.
- FP store addr=0x22 (misaligned) -> no mem_en pulse, ack_f one cycle after the request is seen, resp_err=1, rdata=0.
- TIMEOUT=3, mem_ready held low -> mem_en high for 3 cycles, then ack with resp_err=1; timeout_cnt=1.
- rst asserted while in ACCESS with mem_ready pending -> mem_en and all acks drop immediately; after release, a held req_f is re-served cleanly with no spurious ack.
